// File: rtl/bo_job_scheduler.sv
// Round-robin arbiter and 5-step sequencer that shares one operative block (BO)
// among NREQ requesters. It drives the BO control word and reports job completion.
module bo_job_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            stall,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  x_sel,
    output logic            busy,
    output logic            done,
    output logic [IDW-1:0]  done_id,
    output logic [CNTW-1:0] jobs_done,
    output logic            LX,
    output logic            LS,
    output logic            LH,
    output logic            H,
    output logic [1:0]      M0,
    output logic [1:0]      M1,
    output logic [1:0]      M2
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_DONE
    } state_t;

    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_x_sel;
    logic [IDW-1:0]  r_done_id;
    logic [CNTW-1:0] r_jobs_done;

    logic [NREQ-1:0] w_req_eff;
    logic [IDW-1:0]  w_rot_idx [NREQ];
    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [NREQ-1:0] w_winner_onehot;
    logic [IDW-1:0]  w_ptr_next;
    logic            w_grant_load;
    logic            w_grant_clear;
    logic            w_enter_done;

    // While finishing a job, the requester just served must not win again immediately.
    assign w_req_eff = (r_state == ST_DONE) ? (req & ~r_gnt) : req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] w_sum;
            assign w_sum         = {1'b0, r_rr_ptr} + (IDW+1)'(gi);
            assign w_rot_idx[gi] = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : IDW'(w_sum);
        end
    endgenerate

    // Scan from the highest offset down so the candidate closest to r_rr_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_eff[w_rot_idx[k]]) begin
                w_found  = 1'b1;
                w_winner = w_rot_idx[k];
            end
        end
    end

    assign w_winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_ptr_next      = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_grant_load  = 1'b0;
        w_grant_clear = 1'b0;
        w_enter_done  = 1'b0;
        M0 = 2'd0;
        M1 = 2'd0;
        M2 = 2'd0;
        LX = 1'b0;
        LS = 1'b0;
        LH = 1'b0;
        H  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_S1;
                    w_grant_load = 1'b1;
                end
            end
            ST_S1: begin
                M1 = 2'd1; LX = 1'b1; LH = 1'b1; H = 1'b1;
                if (!stall) w_state_next = ST_S2;
            end
            ST_S2: begin
                M0 = 2'd1; M2 = 2'd3; LS = 1'b1; H = 1'b1;
                if (!stall) w_state_next = ST_S3;
            end
            ST_S3: begin
                M0 = 2'd2; LH = 1'b1; H = 1'b1;
                if (!stall) w_state_next = ST_S4;
            end
            ST_S4: begin
                M1 = 2'd2; M2 = 2'd3; LS = 1'b1;
                if (!stall) w_state_next = ST_S5;
            end
            ST_S5: begin
                M0 = 2'd3; M2 = 2'd2; LS = 1'b1;
                if (!stall) begin
                    w_state_next = ST_DONE;
                    w_enter_done = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_found) begin
                    w_state_next = ST_S1;
                    w_grant_load = 1'b1;
                end else begin
                    w_state_next  = ST_IDLE;
                    w_grant_clear = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // A stalled step must not commit any BO register; selects stay put.
        if (stall) begin
            LX = 1'b0;
            LS = 1'b0;
            LH = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_x_sel     <= '0;
            r_done_id   <= '0;
            r_jobs_done <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_load) begin
                r_gnt    <= w_winner_onehot;
                r_x_sel  <= w_winner;
                r_rr_ptr <= w_ptr_next;
            end else if (w_grant_clear) begin
                r_gnt <= '0;
            end
            if (w_enter_done) begin
                r_done_id <= r_x_sel;
                if (r_jobs_done != '1) r_jobs_done <= r_jobs_done + 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign x_sel     = r_x_sel;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign done_id   = r_done_id;
    assign jobs_done = r_jobs_done;

endmodule

// File: tb/tb_bo_job_scheduler.sv
// Directed bench for bo_job_scheduler: a per-cycle vector table for reset, single-job
// and stall sequences, plus hand-written back-to-back, mid-job reset and queued-request runs.
module tb_bo_job_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        stall;
    logic [3:0]  gnt;
    logic [1:0]  x_sel;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [15:0] jobs_done;
    logic        LX, LS, LH, H;
    logic [1:0]  M0, M1, M2;

    int n_checks = 0;
    int n_errors = 0;

    bo_job_scheduler #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .gnt(gnt), .x_sel(x_sel), .busy(busy), .done(done), .done_id(done_id),
        .jobs_done(jobs_done), .LX(LX), .LS(LS), .LH(LH), .H(H),
        .M0(M0), .M1(M1), .M2(M2)
    );

    always #5 clk = ~clk;

    // Control word packing: {M0, M1, M2, LX, LS, LH, H}
    localparam logic [9:0] CW_0     = 10'b00_00_00_0000;
    localparam logic [9:0] CW_S1    = 10'b00_01_00_1011;
    localparam logic [9:0] CW_S2    = 10'b01_00_11_0101;
    localparam logic [9:0] CW_S3    = 10'b10_00_00_0011;
    localparam logic [9:0] CW_S3_ST = 10'b10_00_00_0001;
    localparam logic [9:0] CW_S4    = 10'b00_10_11_0100;
    localparam logic [9:0] CW_S5    = 10'b11_00_10_0100;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic        stall;
        logic [3:0]  gnt;
        logic        busy;
        logic        done;
        logic [1:0]  did;
        logic [9:0]  cw;
        logic        jchk;
        logic [15:0] jobs;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input string n, input logic [3:0] rq, input logic st,
                        input logic [3:0] g, input logic b, input logic d,
                        input logic [1:0] di, input logic [9:0] cw,
                        input logic jc, input logic [15:0] j);
        vec_t t;
        t.name = n; t.req = rq; t.stall = st; t.gnt = g; t.busy = b; t.done = d;
        t.did = di; t.cw = cw; t.jchk = jc; t.jobs = j;
        vq.push_back(t);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; stall = 1'b0;
        adv(); adv();
        reset = 1'b0;
    endtask

    logic [17:0] act_bits, exp_bits;

    initial begin
        // Reset idle, single job, stall during S3 (stall also set in IDLE and DONE, where it must be ignored)
        for (int i = 0; i < 5; i++) addv("t1_idle", 4'h0, 0, 4'h0, 0, 0, 2'd0, CW_0, 1, 16'd0);
        addv("t2_req",  4'h1, 0, 4'h0, 0, 0, 2'd0, CW_0,  1, 16'd0);
        addv("t2_s1",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S1, 1, 16'd0);
        addv("t2_s2",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S2, 1, 16'd0);
        addv("t2_s3",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S3, 1, 16'd0);
        addv("t2_s4",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S4, 1, 16'd0);
        addv("t2_s5",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S5, 1, 16'd0);
        addv("t2_done", 4'h0, 0, 4'h1, 1, 1, 2'd0, CW_0,  0, 16'd0);
        addv("t2_idle", 4'h0, 0, 4'h0, 0, 0, 2'd0, CW_0,  1, 16'd1);
        addv("t4_req",  4'h1, 1, 4'h0, 0, 0, 2'd0, CW_0,     1, 16'd1);
        addv("t4_s1",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S1,    1, 16'd1);
        addv("t4_s2",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S2,    1, 16'd1);
        addv("t4_s3_st",4'h0, 1, 4'h1, 1, 0, 2'd0, CW_S3_ST, 1, 16'd1);
        addv("t4_s3_st",4'h0, 1, 4'h1, 1, 0, 2'd0, CW_S3_ST, 1, 16'd1);
        addv("t4_s3",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S3,    1, 16'd1);
        addv("t4_s4",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S4,    1, 16'd1);
        addv("t4_s5",   4'h0, 0, 4'h1, 1, 0, 2'd0, CW_S5,    1, 16'd1);
        addv("t4_done", 4'h0, 1, 4'h1, 1, 1, 2'd0, CW_0,     0, 16'd1);
        addv("t4_idle", 4'h0, 0, 4'h0, 0, 0, 2'd0, CW_0,     1, 16'd2);

        reset = 1'b1; req = '0; stall = 1'b0;
        repeat (3) adv();
        reset = 1'b0;

        foreach (vq[i]) begin
            req = vq[i].req;
            stall = vq[i].stall;
            settle();
            act_bits = {gnt, busy, done, done_id, M0, M1, M2, LX, LS, LH, H};
            exp_bits = {vq[i].gnt, vq[i].busy, vq[i].done, vq[i].did, vq[i].cw};
            $display("vec %0d %s outputs=%h", i, vq[i].name, act_bits);
            chk(vq[i].name, 32'(act_bits), 32'(exp_bits));
            if (vq[i].jchk) chk({vq[i].name, "_jobs"}, 32'(jobs_done), 32'(vq[i].jobs));
            adv();
        end
        stall = 1'b0;

        // All four requesting continuously: grants 0,1,2,3,0 with no idle gap
        do_reset();
        req = 4'hF;
        settle();
        chk("t3_idle_busy", 32'(busy), 32'd0);
        adv();
        for (int j = 0; j < 5; j++) begin
            for (int c = 1; c <= 6; c++) begin
                if (j == 4 && c == 1) req = 4'h0;
                settle();
                chk("t3_gnt", 32'(gnt), 32'(1) << (j % 4));
                chk("t3_busy", 32'(busy), 32'd1);
                chk("t3_done", 32'(done), 32'(c == 6));
                if (c == 6) begin
                    chk("t3_done_id", 32'(done_id), 32'(j % 4));
                    $display("job %0d finished by requester %0d", j, done_id);
                end
                adv();
            end
        end
        settle();
        chk("t3_end_busy", 32'(busy), 32'd0);
        chk("t3_end_gnt", 32'(gnt), 32'd0);
        chk("t3_jobs", 32'(jobs_done), 32'd5);
        adv();

        // Reset asserted in S4 aborts the job with no done
        do_reset();
        req = 4'h1;
        settle();
        adv();
        req = 4'h0;
        adv(); adv(); adv();
        settle();
        chk("t5_in_s4", 32'({M0, M1, M2, LX, LS, LH, H}), 32'(CW_S4));
        reset = 1'b1;
        adv();
        reset = 1'b0;
        settle();
        chk("t5_outputs", 32'({gnt, busy, done, done_id, M0, M1, M2, LX, LS, LH, H}), 32'd0);
        chk("t5_jobs", 32'(jobs_done), 32'd0);
        chk("t5_x_sel", 32'(x_sel), 32'd0);
        for (int c = 0; c < 7; c++) begin
            adv();
            settle();
            chk("t5_no_done", 32'({busy, done}), 32'd0);
        end
        $display("mid-job reset sequence complete, jobs_done=%0d", jobs_done);
        adv();

        // Request 2 arrives during S2 of job 0 and is served straight after DONE
        do_reset();
        req = 4'h1;
        settle();
        adv();
        req = 4'h0;
        settle();
        chk("t6_s1_gnt", 32'(gnt), 32'h1);
        adv();
        req = 4'h4;
        for (int c = 2; c <= 5; c++) begin
            settle();
            chk("t6_job0_gnt", 32'(gnt), 32'h1);
            adv();
        end
        settle();
        chk("t6_done0", 32'({done, done_id}), 32'({1'b1, 2'd0}));
        chk("t6_done0_gnt", 32'(gnt), 32'h1);
        adv();
        req = 4'h0;
        settle();
        chk("t6_gnt2", 32'(gnt), 32'h4);
        chk("t6_xsel2", 32'(x_sel), 32'd2);
        chk("t6_s1_cw", 32'({busy, M0, M1, M2, LX, LS, LH, H}), 32'({1'b1, CW_S1}));
        repeat (5) adv();
        settle();
        chk("t6_done2", 32'({done, done_id}), 32'({1'b1, 2'd2}));
        $display("queued job finished by requester %0d", done_id);
        adv();
        settle();
        chk("t6_idle", 32'({busy, gnt}), 32'd0);
        chk("t6_jobs", 32'(jobs_done), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
